// File: rtl/ustc_acc_pkg.sv
// ustc_acc_pkg: lane field layout, ctrl bit indices, bank states and sizing shared by the accumulation buffer
package ustc_acc_pkg;
  localparam int N_UNIT  = 32;
  localparam int DW_DATA = 8;
  localparam int DW_ROW  = 4;
  localparam int DW_CTRL = 4;
  localparam int DW_OUT  = 16;
  localparam int DW_ACC  = 24;
  localparam int DATA_LSB = 0;
  localparam int ROW_LSB  = DATA_LSB + DW_DATA;
  localparam int CTRL_LSB = ROW_LSB + DW_ROW;
  localparam int CTRL_VALID    = 0;
  localparam int CTRL_TILE_END = 1;
  typedef enum logic [1:0] {FREE, SEALED, DRAIN} bank_st_e;
  function automatic int n_rows(input int dw_row);
    return 1 << dw_row;
  endfunction
  localparam int N_ROWS = n_rows(DW_ROW);
endpackage

// File: rtl/ustc_acc_bank.sv
// ustc_acc_bank: N_ROWS x DW_ACC accumulator bank with per-row add, read and read-and-clear
// Ports: clk, reset (async active-low); add_en_i/add_i: add one value per row;
// clr_en_i/clr_row_i: zero one row (wins over add); rd_row_i/rd_data_o: combinational row read
module ustc_acc_bank import ustc_acc_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              add_en_i,
  input  logic [DW_ACC-1:0] add_i [N_ROWS],
  input  logic              clr_en_i,
  input  logic [DW_ROW-1:0] clr_row_i,
  input  logic [DW_ROW-1:0] rd_row_i,
  output logic [DW_ACC-1:0] rd_data_o
);
  logic [DW_ACC-1:0] acc_q [N_ROWS];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int r = 0; r < N_ROWS; r++) acc_q[r] <= '0;
    else for (int r = 0; r < N_ROWS; r++)
      acc_q[r] <= (clr_en_i && clr_row_i == DW_ROW'(r)) ? '0 : add_en_i ? acc_q[r] + add_i[r] : acc_q[r];
  assign rd_data_o = acc_q[rd_row_i];
endmodule

// File: rtl/ustc_acc_buf.sv
// ustc_acc_buf: ping-pong row accumulator between the fan reduction network and a valid/ready drain stream
// Ports: clk, reset (async active-low); in_valid/in: packed lanes {ctrl,row,data} at DW_OUT pitch;
// out_valid/out_ready/out_row/out_data/out_last: registered drain stream, one row per handshake;
// busy: a bank is sealed or draining; overflow: sticky, a tile ended while the other bank was occupied
module ustc_acc_buf import ustc_acc_pkg::*; (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [N_UNIT*DW_OUT-1:0] in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW_ROW-1:0]        out_row,
  output logic [DW_ACC-1:0]        out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overflow
);
  logic [DW_ACC-1:0] sum [N_ROWS];
  logic [DW_ACC-1:0] rd [2];
  logic [DW_ACC-1:0] rd_data, out_data_q, out_data_d;
  logic [DW_ROW-1:0] rd_row, out_row_q, out_row_d;
  logic tile_end, hs, fin, other_free, sb, start, unused_bits;
  logic wb_q, wb_d, db_q, db_d, ovf_q, ovf_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  bank_st_e st_q [2], st_d [2];
  assign unused_bits = ^in;
  always_comb begin
    tile_end = 1'b0;
    for (int r = 0; r < N_ROWS; r++) sum[r] = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      tile_end |= in[i*DW_OUT+CTRL_LSB+CTRL_TILE_END];
      for (int r = 0; r < N_ROWS; r++)
        if (in[i*DW_OUT+CTRL_LSB+CTRL_VALID] && in[i*DW_OUT+ROW_LSB +: DW_ROW] == DW_ROW'(r))
          sum[r] += DW_ACC'($signed(in[i*DW_OUT+DATA_LSB +: DW_DATA]));
    end
    tile_end = tile_end & in_valid;
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    ustc_acc_bank u_bank (
      .clk(clk),
      .reset(reset),
      .add_en_i(in_valid && wb_q == 1'(b)),
      .add_i(sum),
      .clr_en_i(hs && db_q == 1'(b)),
      .clr_row_i(out_row_q),
      .rd_row_i(rd_row),
      .rd_data_o(rd[b])
    );
  end
  assign hs = out_valid_q && out_ready;
  assign fin = hs && out_last_q;
  // a bank handing over its last row this cycle already counts as free for a new tile
  assign other_free = st_q[!wb_q] == FREE || (fin && db_q != wb_q);
  assign sb = st_q[1] == SEALED;
  // a sealed bank takes the output as soon as nothing else is presented, or right after the last row
  assign start = (st_q[0] == SEALED || sb) && (!out_valid_q || fin);
  assign rd_row = start ? '0 : out_row_q + 1'b1;
  assign rd_data = rd[start ? sb : db_q];
  always_comb begin
    st_d = st_q;
    wb_d = wb_q;
    db_d = db_q;
    ovf_d = ovf_q | (tile_end && !other_free);
    out_valid_d = out_valid_q;
    out_row_d = out_row_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (fin) st_d[db_q] = FREE;
    if (tile_end && other_free) begin
      st_d[wb_q] = SEALED;
      wb_d = !wb_q;
    end
    if (start) begin
      st_d[sb] = DRAIN;
      db_d = sb;
    end
    if (start || hs) begin
      out_valid_d = start || !fin;
      out_row_d = rd_row;
      out_data_d = rd_data;
      out_last_d = rd_row == DW_ROW'(N_ROWS-1);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q <= '{FREE, FREE};
      wb_q <= 1'b0;
      db_q <= 1'b0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_row_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wb_q <= wb_d;
      db_q <= db_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
      out_row_q <= out_row_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  assign out_valid = out_valid_q;
  assign out_row = out_row_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign overflow = ovf_q;
  assign busy = st_q[0] != FREE || st_q[1] != FREE;
endmodule
